// File: rtl/approx_mult_pipe.sv
// Pipelined approximate unsigned WxW multiplier with per-quadrant approximation modes.
// Optional error statistics counter enabled by defining APPROX_ERR_STAT_EN.

module approx_quad #(
  parameter int H     = 4,
  parameter int TRUNC = 2
) (
  input  logic [H-1:0]   a,
  input  logic [H-1:0]   b,
  input  logic [1:0]     mode,
  output logic [2*H-1:0] p
);
  function automatic logic [2*H-1:0] tmask();
    tmask = '0;
    for (int i = 0; i < 2*H; i++) tmask[i] = (i < TRUNC);
  endfunction

  localparam logic [2*H-1:0] TMASK = tmask();

  logic [2*H-1:0] prod;

  always_comb begin
    prod = {{H{1'b0}}, a} * {{H{1'b0}}, b};
    p    = prod;
    case (mode)
      2'b01:   p = prod & ~TMASK;
      2'b10:   p = prod | TMASK;
      2'b11:   p = '0;
      default: p = prod;
    endcase
  end
endmodule

module approx_mult_pipe #(
  parameter int W     = 8,
  parameter int TRUNC = 2,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_wr,
  input  logic [8:0]     cfg_mode,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_r,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int H  = W / 2;
  localparam int NQ = 4;

  logic [8:0] mode_q, mode_d;

  // Quadrant order: 0=ll, 1=lh (A_lo*B_hi), 2=hl (A_hi*B_lo), 3=hh.
  logic [NQ-1:0][H-1:0]   qa, qb;
  logic [NQ-1:0][2*H-1:0] qp;
  logic [NQ-1:0][2*H-1:0] sp_q, sp_d;
  logic                   sor_q, sor_d;
  logic [2:1]             vld_q, vld_d;
  logic [2*W-1:0]         out_r_q, out_r_d;
  logic [2*W-1:0]         comb_r;
  logic                   s1_en, s2_en, acc, deliver;

  for (genvar q = 0; q < NQ; q++) begin : g_quad
    assign qa[q] = q[1] ? in_a[W-1:H] : in_a[H-1:0];
    assign qb[q] = q[0] ? in_b[W-1:H] : in_b[H-1:0];
    approx_quad #(.H(H), .TRUNC(TRUNC)) u_quad (
      .a    (qa[q]),
      .b    (qb[q]),
      .mode (mode_q[2*q +: 2]),
      .p    (qp[q])
    );
  end

  assign s2_en    = !vld_q[2] | out_ready;
  assign s1_en    = !vld_q[1] | s2_en;
  assign in_ready = s1_en;
  assign acc      = in_valid & in_ready;
  assign deliver  = vld_q[2] & out_ready;

  always_comb begin
    logic [2*W-1:0] ll_x, lh_x, hl_x, hh_x;
    ll_x = {{W{1'b0}}, sp_q[0]};
    lh_x = {{W{1'b0}}, sp_q[1]} << H;
    hl_x = {{W{1'b0}}, sp_q[2]} << H;
    hh_x = {sp_q[3], {W{1'b0}}};
    if (sor_q) comb_r = (ll_x | hh_x) + (lh_x | hl_x);
    else       comb_r = ll_x + lh_x + hl_x + hh_x;
  end

  always_comb begin
    mode_d   = cfg_wr ? cfg_mode : mode_q;
    vld_d    = vld_q;
    sp_d     = sp_q;
    sor_d    = sor_q;
    out_r_d  = out_r_q;
    if (s1_en) begin
      vld_d[1] = acc;
      if (acc) begin
        sp_d  = qp;
        sor_d = mode_q[8];
      end
    end
    if (s2_en) begin
      vld_d[2] = vld_q[1];
      if (vld_q[1]) out_r_d = comb_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= '0;
      vld_q   <= '0;
      sp_q    <= '0;
      sor_q   <= 1'b0;
      out_r_q <= '0;
    end else begin
      mode_q  <= mode_d;
      vld_q   <= vld_d;
      sp_q    <= sp_d;
      sor_q   <= sor_d;
      out_r_q <= out_r_d;
    end
  end

  assign out_valid = vld_q[2];
  assign out_r     = out_r_q;

`ifdef APPROX_ERR_STAT_EN
  // Exact product rides alongside the approximate one so the comparison happens at delivery.
  logic [2*W-1:0]   ex1_q, ex1_d, ex2_q, ex2_d;
  logic [CNT_W-1:0] err_q, err_d;

  always_comb begin
    ex1_d = ex1_q;
    ex2_d = ex2_q;
    err_d = err_q;
    if (s1_en && acc) ex1_d = {{W{1'b0}}, in_a} * {{W{1'b0}}, in_b};
    if (s2_en && vld_q[1]) ex2_d = ex1_q;
    if (cfg_wr) err_d = '0;
    else if (deliver && (out_r_q != ex2_q) && (err_q != {CNT_W{1'b1}})) err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex1_q <= '0;
      ex2_q <= '0;
      err_q <= '0;
    end else begin
      ex1_q <= ex1_d;
      ex2_q <= ex2_d;
      err_q <= err_d;
    end
  end

  assign err_cnt = err_q;
`else
  logic unused_deliver;
  assign unused_deliver = deliver;
  assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Scoreboard bench for approx_mult_pipe: arithmetic reference model, random and directed traffic.

module tb_approx_mult_pipe;
  localparam int W = 8, H = 4, TRUNC = 2, CNT_W = 16;

  logic           clk = 0, rst_n = 0;
  logic           cfg_wr = 0;
  logic [8:0]     cfg_mode = '0;
  logic           in_valid = 0, in_ready;
  logic [W-1:0]   in_a = '0, in_b = '0;
  logic           out_valid, out_ready = 1;
  logic [2*W-1:0] out_r;
  logic [CNT_W-1:0] err_cnt;

  approx_mult_pipe #(.W(W), .TRUNC(TRUNC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_mode(cfg_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned r;
    int unsigned exact;
    bit          has_const;
    int unsigned cval;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, errors = 0;
  logic [8:0]  cur_mode = '0;
  int unsigned exp_err = 0;
  bit          const_pend = 0;
  int unsigned const_val = 0;
  bit          held = 0;
  logic [2*W-1:0] held_r;

  function automatic int unsigned model(int unsigned a, int unsigned b, logic [8:0] mode);
    int unsigned p[4];
    int unsigned al, ah, bl, bh, r;
    al = a % 16; ah = a / 16; bl = b % 16; bh = b / 16;
    p[0] = al * bl; p[1] = al * bh; p[2] = ah * bl; p[3] = ah * bh;
    for (int q = 0; q < 4; q++) begin
      case ((mode >> (2*q)) & 3)
        1: p[q] = p[q] - (p[q] % (1 << TRUNC));
        2: p[q] = p[q] | ((1 << TRUNC) - 1);
        3: p[q] = 0;
        default: ;
      endcase
    end
    if (mode[8]) r = ((p[0] | (p[3] << 8)) + ((p[1] | p[2]) << 4)) % 65536;
    else         r = (p[0] + (p[1] << 4) + (p[2] << 4) + (p[3] << 8)) % 65536;
    return r;
  endfunction

  task automatic check(string name, int unsigned act, int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Input sampler: records accepted operands with the mode in force at acceptance.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", in_ready, !(sb.size() == 2 && !out_ready));
      if (in_valid && in_ready) begin
        exp_t e;
        e.r = model(in_a, in_b, cur_mode);
        e.exact = in_a * in_b;
        e.has_const = const_pend;
        e.cval = const_val;
        const_pend = 0;
        sb.push_back(e);
      end
      if (cfg_wr) cur_mode = cfg_mode;
    end
  end

  // Output monitor: pops the scoreboard on each delivery and tracks the error counter.
  always @(negedge clk) begin
    if (rst_n) begin
      check("err_cnt", err_cnt, exp_err);
      if (held) check("stall_hold", out_r, held_r);
      held = 0;
      if (out_valid) begin
        if (sb.size() == 0) check("spurious_out", out_r, 32'hdead);
        else if (out_ready) begin
          exp_t e;
          e = sb.pop_front();
          check("out_r", out_r, e.r);
          if (e.has_const) check("spec_value", out_r, e.cval);
`ifdef APPROX_ERR_STAT_EN
          if (!cfg_wr && e.r != e.exact && exp_err != 65535) exp_err++;
`endif
        end else begin
          held = 1;
          held_r = out_r;
        end
      end
      if (cfg_wr) exp_err = 0;
    end
  end

  task automatic send(int unsigned a, int unsigned b, bit wr = 0, logic [8:0] m = '0);
    bit acc;
    int n = 0;
    in_valid = 1; in_a = a[W-1:0]; in_b = b[W-1:0];
    cfg_wr = wr; cfg_mode = m;
    forever begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      cfg_wr = 0;
      if (acc) break;
      if (++n > 100) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    in_valid = 0;
  endtask

  task automatic set_mode(logic [8:0] m);
    cfg_wr = 1; cfg_mode = m;
    @(posedge clk); #1;
    cfg_wr = 0;
  endtask

  task automatic expect_const(int unsigned v);
    const_pend = 1; const_val = v;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0) begin
      @(posedge clk); #1;
      if (++n > 200) begin
        check("drain_timeout", sb.size(), 0);
        sb.delete();
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  bit rand_done;

  initial begin
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_r", out_r, 0);
    check("rst_err_cnt", err_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    // Spec examples
    expect_const(16'hFE01); send(8'hFF, 8'hFF);
    set_mode(9'h100);
    expect_const(16'h0111); send(8'h11, 8'h11);
    drain();
    set_mode(9'h001); expect_const(16'h0008); send(3, 3);
    set_mode(9'h002); expect_const(16'h000B); send(3, 3);
    set_mode(9'h0C0); expect_const(16'h0000); send(8'hF0, 8'hF0);
    drain();

    // Stall mid-stream
    set_mode(9'h000);
    fork
      for (int i = 0; i < 6; i++) send($urandom_range(0, 255), $urandom_range(0, 255));
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();

    // cfg_wr coincident with acceptance uses the old mode
    expect_const(16'hE100); send(8'hF0, 8'hF0, 1, 9'h0C0);
    expect_const(16'h0000); send(8'hF0, 8'hF0);
    drain();

    // Random traffic with random modes and backpressure
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 9) == 0)
            send($urandom_range(0, 255), $urandom_range(0, 255), 1, 9'($urandom));
          else
            send($urandom_range(0, 255), $urandom_range(0, 255));
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        rand_done = 1;
      end
      while (!rand_done) begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 2) != 0);
      end
    join
    out_ready = 1;
    drain();

    // Reset with two results in flight
    set_mode(9'h155);
    out_ready = 0;
    send(8'h5A, 8'hC3);
    send(8'h77, 8'h99);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_err_cnt", err_cnt, 0);
    sb.delete(); cur_mode = '0; exp_err = 0; held = 0; const_pend = 0;
    @(posedge clk); #1;
    out_ready = 1;
    rst_n = 1;
    expect_const(16'hE100); send(8'hF0, 8'hF0);
    drain();
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=done");
    $fatal(1, "timeout");
  end
endmodule
